// File: rtl/sl_preceptron_pkg.sv
// Shared definitions for the perceptron output packer.
//   - pack_state_t: packer FSM states ST_IDLE..ST_DONE
//   - DEF_*: default geometry (8-bit results, 4 lanes, 8-entry word FIFO)
//   - entry_width(): FIFO entry width = packed word + keep mask + last flag
package sl_preceptron_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_DATA_LANES  = 4;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_ENTRY_WIDTH = DEF_DATA_WIDTH * DEF_DATA_LANES + DEF_DATA_LANES + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PACK  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_t;

  function automatic int entry_width(input int dw, input int dl);
    return dw * dl + dl + 1;
  endfunction

endpackage

// File: rtl/sl_preceptron_word_fifo.sv
// Synchronous show-ahead word FIFO.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (caller guarantees count < DEPTH)
//   pop             consume the head entry (only meaningful with head_valid)
//   head_valid      head entry present on head_data
//   head_data       registered head entry, stable until popped
//   count           total entries held, including the head register
// Storage is an array read through a registered head stage; when the array
// is empty a push goes straight into the head so an empty FIFO presents the
// word one cycle after the push.
module sl_preceptron_word_fifo
  import sl_preceptron_pkg::*;
#(
  parameter int WIDTH = DEF_ENTRY_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] mem_count_reg;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_data_reg;

  logic load;
  logic mem_nonempty;
  logic bypass;
  logic mem_wr;
  logic mem_rd;

  // The head register refills whenever it is empty or being consumed.
  assign load         = !head_valid_reg || pop;
  assign mem_nonempty = (mem_count_reg != '0);
  assign bypass       = load && !mem_nonempty && push;
  assign mem_wr       = push && !bypass;
  assign mem_rd       = load && mem_nonempty;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_count_reg  <= '0;
      head_valid_reg <= 1'b0;
      head_data_reg  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      mem_count_reg <= mem_count_reg + CNT_W'(mem_wr) - CNT_W'(mem_rd);
      if (load) begin
        if (mem_rd) begin
          head_valid_reg <= 1'b1;
          head_data_reg  <= mem[rd_ptr_reg];
        end else if (push) begin
          head_valid_reg <= 1'b1;
          head_data_reg  <= push_data;
        end else begin
          head_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign head_valid = head_valid_reg;
  assign head_data  = head_data_reg;
  assign count      = mem_count_reg + CNT_W'(head_valid_reg);

endmodule

// File: rtl/sl_preceptron_packer.sv
// 1:4 gear packer for the perceptron output path.
// Collects DATA_LANES results of DATA_WIDTH bits into one lane word (lane 0 =
// first result, in the LSBs), queues words in a small FIFO and hands them to
// the writeback side with a valid/ready handshake. A vector's final result
// flushes a partial word (unused lanes zero, keep mask marks used lanes).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   data_in_valid/_ready     result byte handshake
//   data_in, data_in_last    result byte, end-of-vector marker
//   data_out_valid/_ready    packed word handshake
//   data_out, _keep, _last   packed word, lane mask, end-of-vector word
//   start_vector_processing  pulse on the first accepted byte of a vector
//   done_vector_processing   pulse the cycle after the last word leaves
//   err_overflow             sticky protocol error flag
// Build option: SL_PRECEPTRON_PACKER_ERR_EN enables err_overflow, which sets
// when a byte is offered while not ready (including during drain/done).
// Without it err_overflow is tied low and refused bytes are dropped silently.
module sl_preceptron_packer
  import sl_preceptron_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_LANES = DEF_DATA_LANES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             data_in_valid,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             data_in_last,
  output logic                             data_in_ready,
  output logic                             data_out_valid,
  output logic [DATA_WIDTH*DATA_LANES-1:0] data_out,
  output logic [DATA_LANES-1:0]            data_out_keep,
  output logic                             data_out_last,
  input  logic                             data_out_ready,
  output logic                             start_vector_processing,
  output logic                             done_vector_processing,
  output logic                             err_overflow
);

  localparam int WORD_W  = DATA_WIDTH * DATA_LANES;
  localparam int ENTRY_W = entry_width(DATA_WIDTH, DATA_LANES);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W  = $clog2(DATA_LANES);

  pack_state_t state_reg, state_next;
  logic [LANE_W-1:0] lane_idx_reg, lane_idx_next;

  logic [DATA_LANES-1:0][DATA_WIDTH-1:0] word_data;
  logic [DATA_LANES-1:0]                 word_keep;
  logic                                  word_push;
  logic                                  accept;
  logic                                  pop;
  logic                                  lane_last;
  logic [ENTRY_W-1:0]                    head_data;
  logic [CNT_W-1:0]                      fifo_count;

  // Ready depends on registered occupancy only, so a same-cycle pop never
  // opens the input.
  assign data_in_ready = ((state_reg == ST_IDLE) || (state_reg == ST_PACK)) &&
                         (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept        = data_in_valid && data_in_ready;
  assign pop           = data_out_valid && data_out_ready;
  assign lane_last     = (lane_idx_reg == LANE_W'(DATA_LANES - 1));

  // The word pushed this cycle is built combinationally: earlier lanes come
  // from the assembly registers, the current lane takes data_in directly and
  // later lanes are zero. lane_idx is 0 in ST_IDLE, so the same path serves
  // the first byte of a vector.
  generate
    for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (accept && (lane_idx_reg == LANE_W'(gi))) begin
          lane_reg <= data_in;
        end
      end

      assign word_data[gi] = (LANE_W'(gi) == lane_idx_reg) ? data_in :
                             (LANE_W'(gi) <  lane_idx_reg) ? lane_reg : '0;
      assign word_keep[gi] = (LANE_W'(gi) <= lane_idx_reg);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      lane_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lane_idx_reg <= lane_idx_next;
    end
  end

  always_comb begin
    state_next              = state_reg;
    lane_idx_next           = lane_idx_reg;
    word_push               = 1'b0;
    start_vector_processing = 1'b0;
    case (state_reg)
      ST_IDLE, ST_PACK: begin
        if (accept) begin
          start_vector_processing = (state_reg == ST_IDLE);
          word_push = lane_last || data_in_last;
          if (data_in_last) begin
            state_next    = ST_DRAIN;
            lane_idx_next = '0;
          end else begin
            state_next    = ST_PACK;
            lane_idx_next = lane_last ? '0 : lane_idx_reg + LANE_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Leave as the final word is handed off, so done lands on the
        // cycle right after that handshake.
        if ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign done_vector_processing = (state_reg == ST_DONE);

  sl_preceptron_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (word_push),
    .push_data  ({data_in_last, word_keep, word_data}),
    .pop        (pop),
    .head_valid (data_out_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign data_out      = head_data[WORD_W-1:0];
  assign data_out_keep = head_data[WORD_W +: DATA_LANES];
  assign data_out_last = head_data[ENTRY_W-1];

`ifdef SL_PRECEPTRON_PACKER_ERR_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (data_in_valid && !data_in_ready) begin
      err_reg <= 1'b1;
    end
  end

  assign err_overflow = err_reg;
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sl_preceptron_packer.sv
module tb_sl_preceptron_packer;

  logic        clk;
  logic        rst;
  logic        data_in_valid;
  logic [7:0]  data_in;
  logic        data_in_last;
  logic        data_in_ready;
  logic        data_out_valid;
  logic [31:0] data_out;
  logic [3:0]  data_out_keep;
  logic        data_out_last;
  logic        data_out_ready;
  logic        start_vector_processing;
  logic        done_vector_processing;
  logic        err_overflow;

`ifdef SL_PRECEPTRON_PACKER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  sl_preceptron_packer dut (
    .clk                     (clk),
    .rst                     (rst),
    .data_in_valid           (data_in_valid),
    .data_in                 (data_in),
    .data_in_last            (data_in_last),
    .data_in_ready           (data_in_ready),
    .data_out_valid          (data_out_valid),
    .data_out                (data_out),
    .data_out_keep           (data_out_keep),
    .data_out_last           (data_out_last),
    .data_out_ready          (data_out_ready),
    .start_vector_processing (start_vector_processing),
    .done_vector_processing  (done_vector_processing),
    .err_overflow            (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  typedef struct {
    logic [7:0]  base;
    int          n;
    int          nwords;
    logic [31:0] w0;
    logic [3:0]  k0;
    logic        l0;
    logic [31:0] w1;
    logic [3:0]  k1;
    logic        l1;
    bit          chk_lat;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  int    cyc = 0;
  int    start_cnt = 0;
  int    done_cnt = 0;
  int    acc_cnt = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  int    hs_cyc = 0;
  int    first_valid_cyc = 0;
  word_t got[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Output monitor: one line per word handshake, pulse bookkeeping and
  // a hold check whenever the previous cycle was stalled.
  initial begin
    logic        prev_v;
    logic        prev_r;
    logic [36:0] prev_w;
    word_t       w;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_r) begin
          chk("hold", {data_out_valid, data_out, data_out_keep, data_out_last}, {1'b1, prev_w});
        end
        if (data_out_valid && !prev_v) first_valid_cyc = cyc;
        if (data_out_valid && data_out_ready) begin
          w.data = data_out;
          w.keep = data_out_keep;
          w.last = data_out_last;
          got.push_back(w);
          hs_cyc = cyc;
          $display("word out @%0d: data=%08h keep=%h last=%b", cyc, data_out, data_out_keep, data_out_last);
        end
        if (start_vector_processing) begin
          start_cnt++;
          start_cyc = cyc;
        end
        if (done_vector_processing) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (data_in_valid && data_in_ready) acc_cnt++;
        prev_v = data_out_valid;
        prev_r = data_out_ready;
        prev_w = {data_out, data_out_keep, data_out_last};
      end
    end
  end

  task automatic send(input logic [7:0] v, input logic last);
    int t;
    t = 0;
    data_in_valid = 1'b1;
    data_in       = v;
    data_in_last  = last;
    while (!data_in_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) chk("in_ready_timeout", data_in_ready, 1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", (done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    got.delete();
    start_cnt = 0;
    done_cnt  = 0;
    acc_cnt   = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, data_out_valid, 0);
    chk({tag, "_out_data"}, data_out, 0);
    chk({tag, "_out_keep"}, data_out_keep, 0);
    chk({tag, "_out_last"}, data_out_last, 0);
    chk({tag, "_start"}, start_vector_processing, 0);
    chk({tag, "_done"}, done_vector_processing, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  vec_t vecs [3];

  initial begin
    vecs[0] = '{8'h01, 8, 2, 32'h04030201, 4'hF, 1'b0, 32'h08070605, 4'hF, 1'b1, 1'b0};
    vecs[1] = '{8'hA1, 3, 1, 32'h00A3A2A1, 4'h7, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1, 1, 32'h0000005A, 4'h1, 1'b1, 32'h0, 4'h0, 1'b0, 1'b1};

    rst            = 1'b1;
    data_in_valid  = 1'b0;
    data_in        = '0;
    data_in_last   = 1'b0;
    data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors with the sink always ready.
    for (int v = 0; v < 3; v++) begin
      clear_stats();
      for (int i = 0; i < vecs[v].n; i++) begin
        send(8'(vecs[v].base + 8'(i)), (i == vecs[v].n - 1));
      end
      wait_done();
      chk($sformatf("v%0d_nwords", v), got.size(), vecs[v].nwords);
      for (int k = 0; k < vecs[v].nwords && k < got.size(); k++) begin
        chk($sformatf("v%0d_w%0d_data", v, k), got[k].data, (k == 0) ? vecs[v].w0 : vecs[v].w1);
        chk($sformatf("v%0d_w%0d_keep", v, k), got[k].keep, (k == 0) ? vecs[v].k0 : vecs[v].k1);
        chk($sformatf("v%0d_w%0d_last", v, k), got[k].last, (k == 0) ? vecs[v].l0 : vecs[v].l1);
      end
      chk($sformatf("v%0d_start_cnt", v), start_cnt, 1);
      chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      chk($sformatf("v%0d_done_timing", v), done_cyc, hs_cyc + 1);
      if (vecs[v].chk_lat) begin
        chk($sformatf("v%0d_word_after_start", v), first_valid_cyc, start_cyc + 1);
      end
    end

    // Backpressure: 40 bytes into a stalled sink, FIFO fills at 32 bytes.
    clear_stats();
    data_out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(8'(i), (i == 39));
      end
      begin
        repeat (45) @(posedge clk);
        #1;
        chk("bp_accepted", acc_cnt, 32);
        chk("bp_in_ready", data_in_ready, 0);
        chk("bp_head_data", data_out, 32'h03020100);
        data_out_ready = 1'b1;
      end
    join
    wait_done();
    chk("bp_nwords", got.size(), 10);
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      chk($sformatf("bp_w%0d_data", k), got[k].data,
          {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
      chk($sformatf("bp_w%0d_keep", k), got[k].keep, 4'hF);
      chk($sformatf("bp_w%0d_last", k), got[k].last, (k == 9));
    end
    chk("bp_done_cnt", done_cnt, 1);

    // Reset mid-vector with one word queued and two bytes assembled.
    clear_stats();
    data_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(8'(8'h60 + 8'(i)), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h11 + 8'(i)), (i == 3));
    wait_done();
    chk("rst_nwords", got.size(), 1);
    if (got.size() > 0) begin
      chk("rst_w0_data", got[0].data, 32'h14131211);
      chk("rst_w0_keep", got[0].keep, 4'hF);
      chk("rst_w0_last", got[0].last, 1);
    end

    // Byte offered during drain.
    clear_stats();
    data_out_ready = 1'b0;
    send(8'h77, 1'b1);
    chk("drain_in_ready", data_in_ready, 0);
    data_in_valid = 1'b1;
    data_in       = 8'h88;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    chk("err_set", err_overflow, ERR_EXP);
    data_out_ready = 1'b1;
    wait_done();
    chk("err_sticky", err_overflow, ERR_EXP);
    chk("drain_nwords", got.size(), 1);
    if (got.size() > 0) chk("drain_w0", {got[0].data, got[0].keep, got[0].last}, {32'h00000077, 4'h1, 1'b1});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("err_cleared", err_overflow, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
